apb_master: RTL and testbench

//   APB initiator: turns single request/response commands (write or read, 6-bit

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_if.sv | 42 ++++
 rtl/apb_timeout_cnt.sv | 27 ++
 rtl/apb_master.sv | 108 ++++++++++
 tb/tb_apb_master.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator toward the UART APB slave.
package apb_pkg;

  localparam int APB_ADDR_W  = 6;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // UART slave register map
  localparam logic [APB_ADDR_W-1:0] CTRL_ADDR = 6'h04;
  localparam logic [APB_ADDR_W-1:0] TXRX_ADDR = 6'h08;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals seen by the APB initiator.
interface apb_master_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           paddr, psel, penable, pwrite, pwdata
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter: expire flags the last allowed wait cycle.
module apb_timeout_cnt #(
  parameter int TIMEOUT = apb_pkg::APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  output logic expire
);

  localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB initiator: one outstanding command turned into SETUP/ACCESS transfers.
// Optional ACCESS-phase abort enabled by defining APB_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = APB_TIMEOUT
`endif
) (
  input logic          pclk,
  input logic          preset,
  apb_master_if.master bus
);

  state_t state;

  assign bus.cmd_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
  logic expire;

  apb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (pclk),
    .rst   (preset),
    .clear (state == SETUP),
    .load  ((state == ACCESS) && !bus.pready),
    .expire(expire)
  );
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  // NOTE: all state and bus outputs use <= so every branch sees pre-edge values.
  always_ff @(posedge pclk) begin
    // NOTE: reset is synchronous; it only takes effect on a clock edge.
    if (preset) begin
      state       <= IDLE;
      bus.paddr   <= {ADDR_W{1'b0}};
      bus.psel    <= 1'b0;
      bus.penable <= 1'b0;
      bus.pwrite  <= 1'b0;
      bus.pwdata  <= {DATA_W{1'b0}};
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= {DATA_W{1'b0}};
      bus.rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      bus.rsp_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state       <= SETUP;
            bus.psel    <= 1'b1;
            bus.penable <= 1'b0;
            bus.paddr   <= bus.cmd_addr;
            bus.pwrite  <= bus.cmd_write;
            bus.pwdata  <= bus.cmd_wdata;
          end
        end

        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
        end

        ACCESS: begin
          // pready takes priority over a timeout landing on the same cycle
          if (bus.pready) begin
            state         <= RESP;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= (!bus.pwrite && !bus.pslverr) ? bus.prdata
                                                            : {DATA_W{1'b0}};
            bus.rsp_err   <= bus.pslverr;
`ifdef APB_TIMEOUT_EN
            bus.rsp_timeout <= 1'b0;
          end else if (expire) begin
            state           <= RESP;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= {DATA_W{1'b0}};
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
`endif
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of transfers plus corner sequences.
module tb_apb_master;
  import apb_pkg::*;

  logic pclk = 1'b0;
  logic preset;

  apb_master_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  apb_master dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  int    n_total = 0;
  int    n_pass  = 0;
  string cur_tag = "";

  typedef struct {
    logic        write;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s/%s: got 0x%08h expected 0x%08h",
                  cur_tag, name, actual, expected);
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic check_bus(input logic [1:0] exp_sel_en);
    check("psel_penable", 32'({bus.psel, bus.penable}), 32'(exp_sel_en));
  endtask

  // Full transfer; expects IDLE on entry, sampled and driven at negedges.
  task automatic run_xfer(input vec_t v);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_write = ~v.write;
    check_bus(2'b10);
    check("paddr", 32'(bus.paddr), 32'(v.addr));
    check("pwrite", 32'(bus.pwrite), 32'(v.write));
    check("pwdata", bus.pwdata, v.wdata);
    check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    tick();
    for (int i = 0; i < v.waits; i++) begin
      check_bus(2'b11);
      check("paddr_wait", 32'(bus.paddr), 32'(v.addr));
      check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd0);
      bus.pready = 1'b0;
      tick();
    end
    check_bus(2'b11);
    bus.pready  = 1'b1;
    bus.prdata  = v.prdata;
    bus.pslverr = v.slverr;
    tick();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = ~v.prdata;
    check_bus(2'b00);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
    check("cmd_ready_done", 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, TXRX_ADDR, 32'h0000_0055, 0, 32'h1234_5678, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, CTRL_ADDR, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, CTRL_ADDR, 32'h1234_5678, 1, 32'h0,         1'b1, 32'h0, 1'b1};
    vecs[3] = '{1'b0, TXRX_ADDR, 32'h0,         0, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 6'h3F,     32'h0,         2, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0};
    vecs[5] = '{1'b1, 6'h00,     32'hFFFF_FFFF, 0, 32'h1111_1111, 1'b0, 32'h0, 1'b0};
    // pready on the last cycle before a 16-cycle timeout would fire
    vecs[6] = '{1'b0, CTRL_ADDR, 32'h0,        15, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0};

    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    tick();
    tick();
    cur_tag = "reset";
    check_bus(2'b00);
    check("paddr", 32'(bus.paddr), 32'd0);
    check("pwrite", 32'(bus.pwrite), 32'd0);
    check("pwdata", bus.pwdata, 32'd0);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    preset = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) begin
      cur_tag = $sformatf("vec%0d", k);
      run_xfer(vecs[k]);
    end

    // Response backpressure while a new command waits.
    cur_tag = "backpressure";
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = TXRX_ADDR;
    bus.cmd_wdata = 32'h0000_00A1;
    tick();
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = CTRL_ADDR;
    tick();
    bus.pready = 1'b1;
    bus.prdata = 32'h5555_AAAA;
    tick();
    bus.pready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
      check("rsp_rdata_hold", bus.rsp_rdata, 32'd0);
      check("rsp_err_hold", 32'(bus.rsp_err), 32'd0);
      check("cmd_ready_hold", 32'(bus.cmd_ready), 32'd0);
      check_bus(2'b00);
      tick();
    end
    bus.rsp_ready = 1'b1;
    check("rsp_valid_last", 32'(bus.rsp_valid), 32'd1);
    tick();
    bus.rsp_ready = 1'b0;
    check("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    check_bus(2'b00);
    tick();
    bus.cmd_valid = 1'b0;
    check_bus(2'b10);
    check("paddr_next", 32'(bus.paddr), 32'(CTRL_ADDR));
    check("pwrite_next", 32'(bus.pwrite), 32'd0);
    tick();
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_0077;
    tick();
    bus.pready = 1'b0;
    check("rsp_rdata_next", bus.rsp_rdata, 32'h0000_0077);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Stuck slave: abort with the timeout feature, otherwise wait forever.
    cur_tag = "stuck";
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = TXRX_ADDR;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      check_bus(2'b11);
      check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    check_bus(2'b00);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_err", 32'(bus.rsp_err), 32'd1);
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    check("rsp_rdata", bus.rsp_rdata, 32'd0);
`else
    for (int i = 0; i < 100; i++) tick();
    check_bus(2'b11);
    check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd0);
    bus.pready = 1'b1;
    bus.prdata = 32'h0F0F_0F0F;
    tick();
    bus.pready = 1'b0;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("rsp_rdata", bus.rsp_rdata, 32'h0F0F_0F0F);
`endif
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("cmd_ready_done", 32'(bus.cmd_ready), 32'd1);

    // Reset in the middle of ACCESS.
    cur_tag = "mid_reset";
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = CTRL_ADDR;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check_bus(2'b11);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    check_bus(2'b00);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    check_bus(2'b00);
    check("rsp_valid_after", 32'(bus.rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
